mem_copy_engine: RTL

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine_pkg.sv | 19 +
 rtl/mem_copy_engine_if.sv | 33 +++
 rtl/mem_copy_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared widths and state encoding for the memory copy engine
//   ISIZE         : word-address width
//   DSIZE         : data-word width
//   LEN_W_DEFAULT : default width of the transfer-length input
//   state_t       : copy engine FSM states
package mem_copy_engine_pkg;

  localparam int ISIZE         = 16;
  localparam int DSIZE         = 16;
  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - data-memory port between the copy engine and a one-cycle-latency memory
//   mem_memread  : read strobe (engine -> memory)
//   mem_memwrite : write strobe (engine -> memory)
//   mem_addr     : word address (engine -> memory)
//   mem_wdata    : write data (engine -> memory)
//   mem_rdata    : read data, valid the cycle after the read strobe (memory -> engine)
//   modports     : master = engine side, slave = memory side
interface mem_copy_engine_if;
  import mem_copy_engine_pkg::*;

  logic             mem_memread;
  logic             mem_memwrite;
  logic [ISIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic [DSIZE-1:0] mem_rdata;

  modport master (
    output mem_memread,
    output mem_memwrite,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_memread,
    input  mem_memwrite,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - forward word-by-word memory copy engine (READ/WRITE alternation)
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : begin a copy (sampled in IDLE) / terminate an active copy
//   src_addr, dst_addr  : first source / destination word address
//   len                 : number of words to copy (LEN_W bits)
//   busy, done          : high in READ/WRITE / one-cycle completion pulse
//   checksum            : running sum of written words; only built with MEMCOPY_CHECKSUM_EN,
//                         otherwise tied to 0
//   mem                 : data-memory port (mem_copy_engine_if.master)
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ISIZE-1:0]   src_addr,
  input  logic [ISIZE-1:0]   dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic [DSIZE-1:0]   checksum,
  mem_copy_engine_if.master  mem
);

  state_t           state_q;
  state_t           state_d;
  logic [ISIZE-1:0] src_q;
  logic [ISIZE-1:0] dst_q;
  logic [LEN_W-1:0] rem_q;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (len != '0)) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        rem_q <= len;
      end else if (state_q == ST_WRITE) begin
        // Address wrap-around is the natural ISIZE-bit overflow.
        src_q <= src_q + ISIZE'(1);
        dst_q <= dst_q + ISIZE'(1);
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    mem.mem_memread  = 1'b0;
    mem.mem_memwrite = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        mem.mem_memread = 1'b1;
        mem.mem_addr    = src_q;
        state_d         = abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        // Read data registered by the memory on the READ edge is forwarded straight through.
        mem.mem_memwrite = 1'b1;
        mem.mem_addr     = dst_q;
        mem.mem_wdata    = mem.mem_rdata;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done = (state_q == ST_DONE);

`ifdef MEMCOPY_CHECKSUM_EN
  logic [DSIZE-1:0] csum_q;

  // The word written in an aborted WRITE still lands in memory, so it is still summed.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (state_q == ST_WRITE) begin
      csum_q <= csum_q + mem.mem_rdata;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
